// File: rtl/pixel_weight_sequencer.sv
// rtl/pixel_weight_sequencer.sv - per-pixel image/weight feeder for the forward-propagation multiply stage
//
// Walks the NPIX pixels of one frame on start. Each pixel is fetched from the
// image RAM and the matching NOUT-lane weight row from the weight RAM. The
// pixel is thresholded to one bit and presented with a start_stream strobe.
// After the last pixel a drain interval elapses, then frame_done pulses.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   start         begin a frame (accepted only in IDLE)
//   busy          frame in progress, through the frame_done cycle inclusive
//   frame_done    one-cycle end-of-frame pulse
//   pix_addr      image RAM read address  (pix_data valid one cycle later)
//   w_addr        weight RAM read address (w_data valid one cycle later)
//   pixel         thresholded pixel, (pix_data >= THRESH)
//   start_stream  per-pixel strobe, high HI_CYC then low LO_CYC cycles
//   weights_out   registered weight row, lane k at [WW*k +: WW]
//   pixel_index   index of the pixel currently presented
module pixel_weight_sequencer #(
  parameter int NPIX      = 784,
  parameter int NOUT      = 10,
  parameter int WW        = 16,
  parameter int THRESH    = 128,
  parameter int HI_CYC    = 4,
  parameter int LO_CYC    = 2,
  parameter int DRAIN_CYC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  output logic [9:0]           pix_addr,
  input  logic [7:0]           pix_data,
  output logic [9:0]           w_addr,
  input  logic [NOUT*WW-1:0]   w_data,
  output logic                 pixel,
  output logic                 start_stream,
  output logic [NOUT*WW-1:0]   weights_out,
  output logic [9:0]           pixel_index
);

  localparam int MAX_HL = (HI_CYC > LO_CYC) ? HI_CYC : LO_CYC;
  localparam int MAXC   = (MAX_HL > DRAIN_CYC) ? MAX_HL : DRAIN_CYC;
  localparam int CW     = $clog2(MAXC) + 1;
  localparam logic [9:0] LAST = 10'(NPIX - 1);
  localparam logic [8:0] THR  = 9'(THRESH);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, STROBE_HI, STROBE_LO, DRAIN, DONE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   phase;
  logic [9:0]      idx;
  logic            phase_end;

  assign phase_end = (phase == '0);

  // RAM addresses follow idx directly; idx is cleared on leaving DONE so the
  // addresses read 0 whenever the FSM is idle.
  assign pix_addr = idx;
  assign w_addr   = idx;

  // Phase counter load value on entry to a state: remaining cycles minus one.
  function automatic logic [CW-1:0] phase_load(input state_t s);
    case (s)
      STROBE_HI: return CW'(HI_CYC - 1);
      STROBE_LO: return CW'(LO_CYC - 1);
      DRAIN:     return CW'(DRAIN_CYC - 1);
      default:   return '0;
    endcase
  endfunction

  // State register, phase counter and pixel index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      phase <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      // Every multi-cycle state is entered from a different state, so a
      // state change marks exactly one entry and the counter reloads there.
      if (state_nx != state)
        phase <= phase_load(state_nx);
      else if (!phase_end)
        phase <= phase - CW'(1);

      if (state == IDLE && start)
        idx <= '0;
      else if (state == STROBE_LO && phase_end && idx != LAST)
        idx <= idx + 10'd1;
      else if (state == DONE)
        idx <= '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = FETCH;
      FETCH:     state_nx = LATCH;
      LATCH:     state_nx = STROBE_HI;
      STROBE_HI: if (phase_end) state_nx = STROBE_LO;
      STROBE_LO: if (phase_end) state_nx = (idx == LAST) ? DRAIN : FETCH;
      DRAIN:     if (phase_end) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe and never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      start_stream <= 1'b0;
      pixel        <= 1'b0;
      weights_out  <= '0;
      pixel_index  <= '0;
    end else begin
      busy         <= (state_nx != IDLE);
      frame_done   <= (state_nx == DONE);
      start_stream <= (state_nx == STROBE_HI);
      // RAM data addressed in FETCH is valid during LATCH.
      if (state == LATCH) begin
        pixel       <= ({1'b0, pix_data} >= THR);
        weights_out <= w_data;
        pixel_index <= idx;
      end
    end
  end

endmodule

// File: tb/tb_pixel_weight_sequencer.sv
// tb/tb_pixel_weight_sequencer.sv - self-checking bench for pixel_weight_sequencer
module tb_pixel_weight_sequencer;

  localparam int NPIX  = 784;
  localparam int NOUT  = 10;
  localparam int WW    = 16;
  localparam int PER   = 8;
  localparam int PIXC  = NPIX * PER;
  localparam int FRAME = PIXC + 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 busy, frame_done, pixel, start_stream;
  logic [9:0]           pix_addr, w_addr, pixel_index;
  logic [7:0]           pix_data;
  logic [NOUT*WW-1:0]   w_data, weights_out;

  logic [7:0]           img  [NPIX];
  logic [NOUT*WW-1:0]   wmem [NPIX];

  int ntests = 0;
  int nfail  = 0;

  pixel_weight_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .frame_done   (frame_done),
    .pix_addr     (pix_addr),
    .pix_data     (pix_data),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .pixel        (pixel),
    .start_stream (start_stream),
    .weights_out  (weights_out),
    .pixel_index  (pixel_index)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAMs: data valid one cycle after the address.
  always @(posedge clk) begin
    pix_data <= img[pix_addr];
    w_data   <= wmem[w_addr];
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit all200);
    for (int i = 0; i < NPIX; i++) begin
      img[i] = all200 ? 8'd200 : 8'($urandom);
      for (int k = 0; k < NOUT; k++)
        wmem[i][WW*k +: WW] = 16'($urandom);
    end
    if (!all200) begin
      img[0] = 8'd127;
      img[1] = 8'd128;
      img[2] = 8'd255;
      img[3] = 8'd0;
    end
    for (int k = 0; k < NOUT; k++)
      wmem[5][WW*k +: WW] = 16'(1000 * k - 4000);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ss"},    160'(start_stream), 160'(0));
    chk({tag, "_busy"},  160'(busy), 160'(0));
    chk({tag, "_done"},  160'(frame_done), 160'(0));
    chk({tag, "_pix"},   160'(pixel), 160'(0));
    chk({tag, "_pidx"},  160'(pixel_index), 160'(0));
    chk({tag, "_w"},     160'(weights_out), 160'(0));
    chk({tag, "_paddr"}, 160'(pix_addr), 160'(0));
    chk({tag, "_waddr"}, 160'(w_addr), 160'(0));
  endtask

  // Starts a frame from IDLE at a negedge and follows it cycle by cycle.
  // Cycle t counts from the edge that accepts start; pixel p owns cycles
  // 8p..8p+7: fetch, latch, four strobe-high, two strobe-low.
  task automatic run_frame(input int abort_t, input bit inject, input bit directed);
    int   strobes;
    logic prev_ss;
    bit   p0_tab [4];
    p0_tab = '{1'b0, 1'b1, 1'b1, 1'b0};
    strobes = 0;
    prev_ss = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t <= FRAME + 1; t++) begin
      int p, ph, h;
      bit in_pix, exp_ss;
      p      = t / PER;
      ph     = t % PER;
      in_pix = (t < PIXC);
      exp_ss = in_pix && ph >= 2 && ph <= 5;
      chk("start_stream", 160'(start_stream), 160'(exp_ss));
      chk("busy",         160'(busy), 160'(t <= FRAME));
      chk("frame_done",   160'(frame_done), 160'(t == FRAME));
      chk("pix_addr", 160'(pix_addr), in_pix ? 160'(p) : (t <= FRAME ? 160'(NPIX - 1) : 160'(0)));
      chk("w_addr",   160'(w_addr),   in_pix ? 160'(p) : (t <= FRAME ? 160'(NPIX - 1) : 160'(0)));
      // Presented pixel: the current one from strobe-high on, the previous
      // one during fetch/latch, the last one after the pixel walk.
      h = !in_pix ? NPIX - 1 : (ph >= 2 ? p : p - 1);
      if (h >= 0) begin
        chk("pixel",       160'(pixel), 160'(img[h] >= 8'd128));
        chk("pixel_index", 160'(pixel_index), 160'(h));
        chk("weights_out", 160'(weights_out), 160'(wmem[h]));
      end
      if (directed && in_pix && ph >= 2) begin
        if (p < 4)
          chk("thresh_boundary", 160'(pixel), 160'(p0_tab[p]));
        if (p == 5) begin
          chk("lane0", 160'(weights_out[15:0]), 160'(16'hF060));
          chk("lane9", 160'(weights_out[159:144]), 160'(16'h1388));
        end
      end
      if (start_stream && !prev_ss)
        strobes++;
      prev_ss = start_stream;
      if (t == FRAME + 1)
        break;
      if (t == abort_t) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("abort");
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          chk("abort_no_done", 160'(frame_done), 160'(0));
          chk("abort_idle",    160'(busy), 160'(0));
        end
        return;
      end
      start = inject && (t == 300 * PER + 3 || t == FRAME);
      @(negedge clk);
    end
    start = 1'b0;
    chk("strobe_count", 160'(strobes), 160'(NPIX));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill(1'b1);
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_paddr", 160'(pix_addr), 160'(0));
      chk("idle_waddr", 160'(w_addr), 160'(0));
      chk("idle_busy",  160'(busy), 160'(0));
      chk("idle_ss",    160'(start_stream), 160'(0));
    end

    run_frame(-1, 1'b0, 1'b0);
    fill(1'b0);
    run_frame(-1, 1'b0, 1'b1);
    fill(1'b0);
    run_frame(-1, 1'b1, 1'b1);
    fill(1'b0);
    run_frame(-1, 1'b0, 1'b1);
    @(negedge clk);
    run_frame(400 * PER + 3, 1'b0, 1'b1);
    fill(1'b0);
    run_frame(-1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
